// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the vending machine.
//   - display state codes (also decoded by the seven-segment generator)
//   - accepted coin bounds and accumulator ceilings
//   - price_of(id): unit price in yuan of each of the four items
package vend_pkg;

    // Display state codes
    localparam logic [3:0] ST_OFF     = 4'b0000;
    localparam logic [3:0] ST_INQUIRE = 4'b0001;
    localparam logic [3:0] ST_ADD     = 4'b0011;
    localparam logic [3:0] ST_COIN    = 4'b0010;
    localparam logic [3:0] ST_SUCCESS = 4'b0110;
    localparam logic [3:0] ST_FAILURE = 4'b0111;
    localparam logic [3:0] ST_SOLDOUT = 4'b1000;

    // Coins outside [COIN_MIN, COIN_MAX] are ignored
    localparam logic [3:0] COIN_MIN = 4'd1;
    localparam logic [3:0] COIN_MAX = 4'd10;

    // Two-digit and three-digit display ceilings
    localparam logic [6:0] PAID_MAX  = 7'd99;
    localparam logic [9:0] TOTAL_MAX = 10'd999;

    // Unit price per item id
    function automatic logic [6:0] price_of(input logic [1:0] item_id);
        logic [6:0] price_v;
        case (item_id)
            2'd0:    price_v = 7'd3;
            2'd1:    price_v = 7'd4;
            2'd2:    price_v = 7'd5;
            2'd3:    price_v = 7'd6;
            default: price_v = 7'd3;
        endcase
        return price_v;
    endfunction

endpackage

// File: rtl/vend_ctrl_bin_to_bcd.sv
// bin_to_bcd: combinational double-dabble converter.
//   bin  : 10-bit binary value (0..999 is the meaningful range)
//   huns : BCD hundreds digit
//   tens : BCD tens digit
//   ones : BCD ones digit
module bin_to_bcd
    import vend_pkg::*;
(
    input  logic [9:0] bin,
    output logic [3:0] huns,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    // A BCD column holding 5..9 must be corrected by +3 before it is doubled
    function automatic logic [3:0] add3(input logic [3:0] digit);
        return (digit > 4'd4) ? (digit + 4'd3) : digit;
    endfunction

    // Layout: [21:18] hundreds, [17:14] tens, [13:10] ones, [9:0] binary
    logic [21:0] scratch_s;

    // Shift the binary value into the BCD columns one bit at a time
    always_comb begin
        scratch_s = {12'd0, bin};
        for (int i = 0; i < 10; i++) begin
            scratch_s[21:18] = add3(scratch_s[21:18]);
            scratch_s[17:14] = add3(scratch_s[17:14]);
            scratch_s[13:10] = add3(scratch_s[13:10]);
            scratch_s        = {scratch_s[20:0], 1'b0};
        end
    end

    assign huns = scratch_s[21:18];
    assign tens = scratch_s[17:14];
    assign ones = scratch_s[13:10];

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending machine transaction sequencer.
// Owns the display state code, current item, per-item stock, payment,
// change and revenue accounting and the one-second timeouts.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   tick_1s                : one-cycle strobe per second
//   power                  : level, low forces OFF
//   btn_next/buy/cancel    : one-cycle button strobes
//   coin_valid, coin_val   : coin strobe and value in yuan
//   state, id, qty         : display state code, item, quantity
//   id_change, done        : registered one-cycle pulses
//   *_tens/*_ones/*_huns   : BCD views of stock, bill, paid, charge, total
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int INIT_STOCK   = 10,
    parameter int COIN_TIMEOUT = 30,
    parameter int MSG_HOLD     = 2,
    parameter int MAX_QTY      = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1s,
    input  logic       power,
    input  logic       btn_next,
    input  logic       btn_buy,
    input  logic       btn_cancel,
    input  logic       coin_valid,
    input  logic [3:0] coin_val,
    output logic [3:0] state,
    output logic [1:0] id,
    output logic       id_change,
    output logic [3:0] qty,
    output logic [3:0] stock_tens,
    output logic [3:0] stock_ones,
    output logic [3:0] bill_tens,
    output logic [3:0] bill_ones,
    output logic [3:0] paid_tens,
    output logic [3:0] paid_ones,
    output logic [3:0] charge_tens,
    output logic [3:0] charge_ones,
    output logic [3:0] total_huns,
    output logic [3:0] total_tens,
    output logic [3:0] total_ones,
    output logic       done
);

    localparam logic [6:0] INIT_STOCK_C = 7'(INIT_STOCK);
    localparam logic [4:0] COIN_TMO_C   = 5'(COIN_TIMEOUT);
    localparam logic [4:0] MSG_HOLD_C   = 5'(MSG_HOLD);
    localparam logic [6:0] MAX_QTY_C    = 7'(MAX_QTY);

    // Registers
    logic [3:0] state_r;
    logic [1:0] id_r;
    logic [3:0] qty_r;
    logic [6:0] paid_r;
    logic [6:0] bill_r;
    logic [6:0] charge_r;
    logic [9:0] total_r;
    logic [4:0] timer_r;
    logic       id_change_r;
    logic       done_r;
    logic [6:0] stock_r [4];

    // Next values
    logic [3:0] state_nxt_s;
    logic [1:0] id_nxt_s;
    logic [3:0] qty_nxt_s;
    logic [6:0] paid_nxt_s;
    logic [6:0] bill_nxt_s;
    logic [6:0] charge_nxt_s;
    logic [9:0] total_nxt_s;
    logic [4:0] timer_nxt_s;
    logic       id_change_nxt_s;
    logic       done_nxt_s;
    logic       stock_dec_s;

    // Shared decode
    logic [6:0]  stock_cur_s;
    logic        coin_ok_s;
    logic [7:0]  paid_sum_s;
    logic [6:0]  paid_new_s;
    logic        pay_done_s;
    logic        expire_s;
    logic [6:0]  qty_lim_s;
    logic [6:0]  bill_calc_s;
    logic [10:0] total_sum_s;
    logic [9:0]  total_sat_s;

    assign stock_cur_s = stock_r[id_r];
    assign coin_ok_s   = coin_valid && (coin_val >= COIN_MIN) && (coin_val <= COIN_MAX);
    assign paid_sum_s  = {1'b0, paid_r} + {4'b0000, coin_val};
    // Payment is applied before any cancel or timeout decision in the same cycle
    assign paid_new_s  = !coin_ok_s ? paid_r :
                         (paid_sum_s > {1'b0, PAID_MAX}) ? PAID_MAX : paid_sum_s[6:0];
    assign pay_done_s  = coin_ok_s && (paid_new_s >= bill_r);
    // Expiry is the tick that would take the timer from 1 to 0
    assign expire_s    = tick_1s && (timer_r == 5'd1);
    assign qty_lim_s   = (stock_cur_s < MAX_QTY_C) ? stock_cur_s : MAX_QTY_C;
    assign bill_calc_s = price_of(id_r) * {3'b000, qty_r};
    assign total_sum_s = {1'b0, total_r} + {4'b0000, bill_r};
    assign total_sat_s = (total_sum_s > {1'b0, TOTAL_MAX}) ? TOTAL_MAX : total_sum_s[9:0];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_OFF;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; power low overrides every state
    always_comb begin
        state_nxt_s = state_r;
        if (!power) begin
            state_nxt_s = ST_OFF;
        end else begin
            case (state_r)
                ST_OFF: begin
                    state_nxt_s = ST_INQUIRE;
                end
                ST_INQUIRE: begin
                    if (btn_cancel) begin
                        state_nxt_s = state_r;
                    end else if (btn_buy) begin
                        if (stock_cur_s == 7'd0) begin
                            state_nxt_s = ST_SOLDOUT;
                        end else begin
                            state_nxt_s = ST_ADD;
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_ADD: begin
                    if (btn_cancel) begin
                        state_nxt_s = ST_INQUIRE;
                    end else if (btn_buy) begin
                        state_nxt_s = ST_COIN;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_COIN: begin
                    if (pay_done_s) begin
                        state_nxt_s = ST_SUCCESS;
                    end else if (btn_cancel || expire_s) begin
                        state_nxt_s = ST_FAILURE;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_SUCCESS, ST_FAILURE, ST_SOLDOUT: begin
                    if (expire_s) begin
                        state_nxt_s = ST_INQUIRE;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_OFF;
                end
            endcase
        end
    end

    // FSM output logic: next values of the datapath registers and pulses
    always_comb begin
        id_nxt_s        = id_r;
        qty_nxt_s       = qty_r;
        paid_nxt_s      = paid_r;
        bill_nxt_s      = bill_r;
        charge_nxt_s    = charge_r;
        total_nxt_s     = total_r;
        timer_nxt_s     = timer_r;
        id_change_nxt_s = 1'b0;
        done_nxt_s      = 1'b0;
        stock_dec_s     = 1'b0;
        if (!power) begin
            // Losing power abandons the transaction; stock and revenue survive
            qty_nxt_s    = 4'd0;
            paid_nxt_s   = 7'd0;
            bill_nxt_s   = 7'd0;
            charge_nxt_s = 7'd0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    id_nxt_s        = 2'd0;
                    id_change_nxt_s = (id_r != 2'd0);
                end
                ST_INQUIRE: begin
                    if (btn_cancel) begin
                        id_nxt_s = id_r;
                    end else if (btn_buy) begin
                        if (stock_cur_s == 7'd0) begin
                            timer_nxt_s = MSG_HOLD_C;
                        end else begin
                            qty_nxt_s = 4'd1;
                        end
                    end else if (btn_next) begin
                        id_nxt_s        = id_r + 2'd1;
                        id_change_nxt_s = 1'b1;
                    end else begin
                        id_nxt_s = id_r;
                    end
                end
                ST_ADD: begin
                    if (btn_cancel) begin
                        qty_nxt_s = 4'd0;
                    end else if (btn_buy) begin
                        bill_nxt_s  = bill_calc_s;
                        paid_nxt_s  = 7'd0;
                        timer_nxt_s = COIN_TMO_C;
                    end else if (btn_next) begin
                        // Quantity cycles 1..min(stock, MAX_QTY)
                        qty_nxt_s = ({3'b000, qty_r} >= qty_lim_s) ? 4'd1 : (qty_r + 4'd1);
                    end else begin
                        qty_nxt_s = qty_r;
                    end
                end
                ST_COIN: begin
                    paid_nxt_s = paid_new_s;
                    if (pay_done_s) begin
                        charge_nxt_s = paid_new_s - bill_r;
                        stock_dec_s  = 1'b1;
                        total_nxt_s  = total_sat_s;
                        timer_nxt_s  = MSG_HOLD_C;
                    end else if (btn_cancel || expire_s) begin
                        charge_nxt_s = paid_new_s;
                        timer_nxt_s  = MSG_HOLD_C;
                    end else if (tick_1s) begin
                        timer_nxt_s = timer_r - 5'd1;
                    end else begin
                        timer_nxt_s = timer_r;
                    end
                end
                ST_SUCCESS, ST_FAILURE, ST_SOLDOUT: begin
                    if (expire_s) begin
                        qty_nxt_s    = 4'd0;
                        paid_nxt_s   = 7'd0;
                        bill_nxt_s   = 7'd0;
                        charge_nxt_s = 7'd0;
                        done_nxt_s   = 1'b1;
                    end else if (tick_1s) begin
                        timer_nxt_s = timer_r - 5'd1;
                    end else begin
                        timer_nxt_s = timer_r;
                    end
                end
                default: begin
                    qty_nxt_s    = 4'd0;
                    paid_nxt_s   = 7'd0;
                    bill_nxt_s   = 7'd0;
                    charge_nxt_s = 7'd0;
                end
            endcase
        end
    end

    // Datapath and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_r        <= 2'd0;
            qty_r       <= 4'd0;
            paid_r      <= 7'd0;
            bill_r      <= 7'd0;
            charge_r    <= 7'd0;
            total_r     <= 10'd0;
            timer_r     <= 5'd0;
            id_change_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            id_r        <= id_nxt_s;
            qty_r       <= qty_nxt_s;
            paid_r      <= paid_nxt_s;
            bill_r      <= bill_nxt_s;
            charge_r    <= charge_nxt_s;
            total_r     <= total_nxt_s;
            timer_r     <= timer_nxt_s;
            id_change_r <= id_change_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    // Per-item stock; only a completed sale removes items
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                stock_r[i] <= INIT_STOCK_C;
            end
        end else if (stock_dec_s) begin
            stock_r[id_r] <= stock_cur_s - {3'b000, qty_r};
        end
    end

    assign state     = state_r;
    assign id        = id_r;
    assign qty       = qty_r;
    assign id_change = id_change_r;
    assign done      = done_r;

    // BCD views; two-digit fields never populate their hundreds digit
    logic [3:0] unused_stock_huns_s;
    logic [3:0] unused_bill_huns_s;
    logic [3:0] unused_paid_huns_s;
    logic [3:0] unused_charge_huns_s;

    bin_to_bcd u_stock_bcd (
        .bin  ({3'b000, stock_cur_s}),
        .huns (unused_stock_huns_s),
        .tens (stock_tens),
        .ones (stock_ones)
    );

    bin_to_bcd u_bill_bcd (
        .bin  ({3'b000, bill_r}),
        .huns (unused_bill_huns_s),
        .tens (bill_tens),
        .ones (bill_ones)
    );

    bin_to_bcd u_paid_bcd (
        .bin  ({3'b000, paid_r}),
        .huns (unused_paid_huns_s),
        .tens (paid_tens),
        .ones (paid_ones)
    );

    bin_to_bcd u_charge_bcd (
        .bin  ({3'b000, charge_r}),
        .huns (unused_charge_huns_s),
        .tens (charge_tens),
        .ones (charge_ones)
    );

    bin_to_bcd u_total_bcd (
        .bin  (total_r),
        .huns (total_huns),
        .tens (total_tens),
        .ones (total_ones)
    );

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed scenarios followed by randomized traffic, every cycle
// compared against a transaction-level reference model of the sequencer.
module tb_vend_ctrl;

    localparam int INIT_STOCK   = 10;
    localparam int COIN_TIMEOUT = 30;
    localparam int MSG_HOLD     = 2;
    localparam int MAX_QTY      = 9;

    // Display codes as defined for the seven-segment generator
    localparam int S_OFF  = 0;
    localparam int S_INQ  = 1;
    localparam int S_ADD  = 3;
    localparam int S_COIN = 2;
    localparam int S_SUCC = 6;
    localparam int S_FAIL = 7;
    localparam int S_SOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1s;
    logic       power;
    logic       btn_next;
    logic       btn_buy;
    logic       btn_cancel;
    logic       coin_valid;
    logic [3:0] coin_val;
    logic [3:0] state;
    logic [1:0] id;
    logic       id_change;
    logic [3:0] qty;
    logic [3:0] stock_tens, stock_ones;
    logic [3:0] bill_tens, bill_ones;
    logic [3:0] paid_tens, paid_ones;
    logic [3:0] charge_tens, charge_ones;
    logic [3:0] total_huns, total_tens, total_ones;
    logic       done;

    vend_ctrl #(
        .INIT_STOCK   (INIT_STOCK),
        .COIN_TIMEOUT (COIN_TIMEOUT),
        .MSG_HOLD     (MSG_HOLD),
        .MAX_QTY      (MAX_QTY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_1s     (tick_1s),
        .power       (power),
        .btn_next    (btn_next),
        .btn_buy     (btn_buy),
        .btn_cancel  (btn_cancel),
        .coin_valid  (coin_valid),
        .coin_val    (coin_val),
        .state       (state),
        .id          (id),
        .id_change   (id_change),
        .qty         (qty),
        .stock_tens  (stock_tens),
        .stock_ones  (stock_ones),
        .bill_tens   (bill_tens),
        .bill_ones   (bill_ones),
        .paid_tens   (paid_tens),
        .paid_ones   (paid_ones),
        .charge_tens (charge_tens),
        .charge_ones (charge_ones),
        .total_huns  (total_huns),
        .total_tens  (total_tens),
        .total_ones  (total_ones),
        .done        (done)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: machine mode, transaction fields and accounting
    int m_st, m_id, m_qty, m_paid, m_bill, m_charge, m_total;
    int m_ticks;        // ticks seen since entering the current timed state
    int m_idc, m_done;
    int m_stock [4];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_st = S_OFF; m_id = 0; m_qty = 0; m_paid = 0; m_bill = 0;
        m_charge = 0; m_total = 0; m_ticks = 0; m_idc = 0; m_done = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = INIT_STOCK;
    endtask

    // One clock of the machine, following the sales rules
    task automatic model_step(input bit pw, input bit nx, input bit by, input bit cn,
                              input bit cv, input int cval, input bit tk);
        int old_id;
        old_id = m_id;
        m_done = 0;
        if (!pw) begin
            m_st = S_OFF; m_qty = 0; m_paid = 0; m_bill = 0; m_charge = 0;
        end else begin
            case (m_st)
                S_OFF: begin
                    m_st = S_INQ; m_id = 0;
                end
                S_INQ: begin
                    if (!cn && by) begin
                        if (m_stock[m_id] == 0) begin
                            m_st = S_SOLD; m_ticks = 0;
                        end else begin
                            m_st = S_ADD; m_qty = 1;
                        end
                    end else if (!cn && nx) begin
                        m_id = (m_id + 1) % 4;
                    end
                end
                S_ADD: begin
                    if (cn) begin
                        m_st = S_INQ; m_qty = 0;
                    end else if (by) begin
                        m_st = S_COIN; m_bill = (3 + m_id) * m_qty; m_paid = 0; m_ticks = 0;
                    end else if (nx) begin
                        m_qty = (m_qty >= min2(m_stock[m_id], MAX_QTY)) ? 1 : m_qty + 1;
                    end
                end
                S_COIN: begin
                    if (tk) m_ticks++;
                    if (cv && cval >= 1 && cval <= 10) m_paid = min2(m_paid + cval, 99);
                    if (m_paid >= m_bill) begin
                        m_charge = m_paid - m_bill;
                        m_stock[m_id] -= m_qty;
                        m_total = min2(m_total + m_bill, 999);
                        m_st = S_SUCC; m_ticks = 0;
                    end else if (cn || m_ticks >= COIN_TIMEOUT) begin
                        m_charge = m_paid;
                        m_st = S_FAIL; m_ticks = 0;
                    end
                end
                S_SUCC, S_FAIL, S_SOLD: begin
                    if (tk) m_ticks++;
                    if (m_ticks >= MSG_HOLD) begin
                        m_st = S_INQ; m_done = 1;
                        m_qty = 0; m_paid = 0; m_bill = 0; m_charge = 0;
                    end
                end
                default: m_st = S_OFF;
            endcase
        end
        m_idc = (m_id != old_id) ? 1 : 0;
    endtask

    task automatic check_all();
        check_val("state", state, m_st);
        check_val("id", id, m_id);
        check_val("id_change", id_change, m_idc);
        check_val("qty", qty, m_qty);
        check_val("stock_tens", stock_tens, m_stock[m_id] / 10);
        check_val("stock_ones", stock_ones, m_stock[m_id] % 10);
        check_val("bill_tens", bill_tens, m_bill / 10);
        check_val("bill_ones", bill_ones, m_bill % 10);
        check_val("paid_tens", paid_tens, m_paid / 10);
        check_val("paid_ones", paid_ones, m_paid % 10);
        check_val("charge_tens", charge_tens, m_charge / 10);
        check_val("charge_ones", charge_ones, m_charge % 10);
        check_val("total_huns", total_huns, m_total / 100);
        check_val("total_tens", total_tens, (m_total / 10) % 10);
        check_val("total_ones", total_ones, m_total % 10);
        check_val("done", done, m_done);
    endtask

    // Drive one cycle of strobes, advance model and DUT, compare after the edge
    task automatic step(input bit nx, input bit by, input bit cn,
                        input bit cv, input int cval, input bit tk);
        btn_next = nx; btn_buy = by; btn_cancel = cn;
        coin_valid = cv; coin_val = cval[3:0]; tick_1s = tk;
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else model_step(power, nx, by, cn, cv, cval, tk);
        #1;
        check_all();
        btn_next = 1'b0; btn_buy = 1'b0; btn_cancel = 1'b0;
        coin_valid = 1'b0; coin_val = 4'd0; tick_1s = 1'b0;
    endtask

    task automatic idle();        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0); endtask
    task automatic tick();        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1); endtask
    task automatic press_next();  step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0); endtask
    task automatic press_buy();   step(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0); endtask
    task automatic coin(input int v); step(1'b0, 1'b0, 1'b0, 1'b1, v, 1'b0); endtask

    initial begin
        rst_n = 1'b0; power = 1'b0;
        btn_next = 1'b0; btn_buy = 1'b0; btn_cancel = 1'b0;
        coin_valid = 1'b0; coin_val = 4'd0; tick_1s = 1'b0;
        model_reset();

        // Reset values
        idle(); idle();
        check_val("rst_state", state, 0);
        check_val("rst_stock_tens", stock_tens, 1);
        check_val("rst_stock_ones", stock_ones, 0);
        check_val("rst_total_ones", total_ones, 0);
        rst_n = 1'b1; power = 1'b1;
        idle();
        check_val("pwr_on_state", state, 1);

        // Single purchase of item 0
        press_buy();  check_val("t1_add", state, 3);
        press_buy();  check_val("t1_coin", state, 2);
        check_val("t1_bill_ones", bill_ones, 3);
        coin(5);
        check_val("t1_succ", state, 6);
        check_val("t1_charge_ones", charge_ones, 2);
        check_val("t1_stock_ones", stock_ones, 9);
        check_val("t1_total_ones", total_ones, 3);
        tick();       check_val("t1_hold", state, 6);
        tick();
        check_val("t1_back", state, 1);
        check_val("t1_done", done, 1);

        // Item browsing 1,2,3,0,1
        for (int k = 0; k < 5; k++) begin
            press_next();
            check_val("t2_id", id, (k + 1) % 4);
            check_val("t2_idc", id_change, 1);
        end

        // Item 2, qty 2, underpaid then timed out
        press_next(); press_buy(); press_next(); press_buy();
        check_val("t3_bill_tens", bill_tens, 1);
        check_val("t3_bill_ones", bill_ones, 0);
        coin(5); coin(2);
        for (int k = 0; k < COIN_TIMEOUT - 1; k++) tick();
        check_val("t3_still_coin", state, 2);
        tick();
        check_val("t3_fail", state, 7);
        check_val("t3_charge_ones", charge_ones, 7);
        check_val("t3_stock_tens", stock_tens, 1);
        check_val("t3_total_ones", total_ones, 3);
        tick(); tick();

        // Drain item 1, then sold out
        press_next(); press_next(); press_next();
        for (int k = 0; k < 12 && m_stock[1] > 0; k++) begin
            press_buy(); press_buy(); coin(10); tick(); tick();
        end
        press_buy();
        check_val("t4_soldout", state, 8);
        tick();       check_val("t4_hold", state, 8);
        tick();
        check_val("t4_back", state, 1);
        check_val("t4_done", done, 1);

        // Final coin, cancel and last tick coincide: payment wins
        press_next(); press_next(); press_next();
        press_buy(); press_next(); press_buy();
        check_val("t5_bill_ones", bill_ones, 6);
        coin(4);
        for (int k = 0; k < COIN_TIMEOUT - 1; k++) tick();
        step(1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b1);
        check_val("t5_succ", state, 6);
        check_val("t5_charge_ones", charge_ones, 0);
        tick(); tick();

        // Power loss during payment
        press_buy(); press_next(); press_buy(); coin(5);
        check_val("t6_paid_ones", paid_ones, 5);
        power = 1'b0; idle();
        check_val("t6_off", state, 0);
        check_val("t6_paid_ones_off", paid_ones, 0);
        power = 1'b1; idle();
        check_val("t6_inq", state, 1);
        check_val("t6_id", id, 0);
        check_val("t6_stock_ones", stock_ones, 7);
        check_val("t6_total_tens", total_tens, 4);
        check_val("t6_total_ones", total_ones, 9);

        // Reset in the middle of a transaction
        press_buy(); press_buy(); coin(2);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check_val("t7_state", state, 0);
        check_val("t7_total_tens", total_tens, 0);
        check_val("t7_stock_tens", stock_tens, 1);
        idle();
        rst_n = 1'b1;
        idle();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bit nx, by, cn, cv, tk;
            int cval;
            power = ($urandom_range(0, 199) != 0);
            nx    = ($urandom_range(0, 5) == 0);
            by    = ($urandom_range(0, 5) == 0);
            cn    = ($urandom_range(0, 24) == 0);
            cv    = ($urandom_range(0, 3) == 0);
            cval  = int'($urandom_range(0, 15));
            tk    = ($urandom_range(0, 3) == 0);
            step(nx, by, cn, cv, cval, tk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
